// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_feeder
//  Brief    : Buffers one NxN weight tile and one NxN activation tile, then
//             pushes weights, skews activations and flushes for systolic_array.
//  Revision : 1.0
// ============================================================================
module systolic_feeder #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int FLUSH_CYC = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    output logic [N*DW-1:0] weightin,
    output logic [N*DW-1:0] datain,
    output logic            w_load,
    output logic            busy,
    output logic            tile_done
);
    localparam int c_WW     = N * DW;
    localparam int c_BW     = $clog2(2 * N);
    localparam int c_PH_MAX = (FLUSH_CYC > 2 * N - 1) ? FLUSH_CYC : 2 * N - 1;
    localparam int c_PW     = (c_PH_MAX > 1) ? $clog2(c_PH_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WPUSH = 3'd2,
        S_DFEED = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t           r_state;
    logic [c_BW-1:0]  r_beat;
    logic [c_PW-1:0]  r_phase;
    logic [c_WW-1:0]  r_wbuf [N];
    logic [c_WW-1:0]  r_abuf [N];
    logic             r_in_ready;
    logic             r_busy;
    logic             r_w_load;
    logic             r_tile_done;
    logic [c_WW-1:0]  r_weightin;
    logic [c_WW-1:0]  r_datain;

    logic [c_WW-1:0]  w_wrow_next;
    logic [c_WW-1:0]  w_skew_next;
    int               w_skew_t;

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign w_load    = r_w_load;
    assign tile_done = r_tile_done;
    assign weightin  = r_weightin;
    assign datain    = r_datain;

    // Weight row for the next WPUSH cycle: rows leave in reverse order.
    always_comb begin
        w_wrow_next = '0;
        for (int r = 0; r < N; r++) begin
            if (r == N - 2 - int'(r_phase)) w_wrow_next = r_wbuf[r];
        end
    end

    // Skewed activation word for the next DFEED cycle (t=0 when leaving WPUSH).
    assign w_skew_t = (r_state == S_DFEED) ? int'(r_phase) + 1 : 0;

    always_comb begin
        w_skew_next = '0;
        for (int k = 0; k < N; k++) begin
            for (int v = 0; v < N; v++) begin
                if (v == w_skew_t - k) w_skew_next[k*DW +: DW] = r_abuf[v][k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_phase     <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_w_load    <= 1'b0;
            r_tile_done <= 1'b0;
            r_weightin  <= '0;
            r_datain    <= '0;
            for (int i = 0; i < N; i++) begin
                r_wbuf[i] <= '0;
                r_abuf[i] <= '0;
            end
        end else begin
            r_tile_done <= 1'b0;
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (in_valid && r_in_ready) begin
                        for (int i = 0; i < N; i++) begin
                            if (int'(r_beat) == i)     r_wbuf[i] <= in_data;
                            if (int'(r_beat) == N + i) r_abuf[i] <= in_data;
                        end
                        // Last beat is always an activation, so wbuf is complete here.
                        if (int'(r_beat) == 2 * N - 1) begin
                            r_state    <= S_WPUSH;
                            r_beat     <= '0;
                            r_phase    <= '0;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                            r_w_load   <= 1'b1;
                            r_weightin <= r_wbuf[N-1];
                        end else begin
                            r_state <= S_LOAD;
                            r_beat  <= r_beat + 1'b1;
                        end
                    end
                end
                S_WPUSH: begin
                    if (int'(r_phase) == N - 1) begin
                        r_state    <= S_DFEED;
                        r_phase    <= '0;
                        r_w_load   <= 1'b0;
                        r_weightin <= '0;
                        r_datain   <= w_skew_next;
                    end else begin
                        r_phase    <= r_phase + 1'b1;
                        r_weightin <= w_wrow_next;
                    end
                end
                S_DFEED: begin
                    if (int'(r_phase) == 2 * N - 2) begin
                        r_datain <= '0;
                        r_phase  <= '0;
                        if (FLUSH_CYC == 0) begin
                            r_state     <= S_IDLE;
                            r_busy      <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_tile_done <= 1'b1;
                        end else begin
                            r_state <= S_FLUSH;
                        end
                    end else begin
                        r_phase  <= r_phase + 1'b1;
                        r_datain <= w_skew_next;
                    end
                end
                S_FLUSH: begin
                    if (int'(r_phase) == FLUSH_CYC - 1) begin
                        r_state     <= S_IDLE;
                        r_phase     <= '0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_tile_done <= 1'b1;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
